// File: rtl/adc_capture.sv
// Triggered 512-sample ADC capture buffer: 256 pre-trigger, trigger, 255 post-trigger samples.
// Optional build macro ADC_CAPTURE_AUTO_TRIG_EN forces a trigger after 512 samples in WAIT.
module adc_capture (
  input  logic        i_clk_64mhz,
  input  logic        i_master_rst,
  input  logic        i_clk_adc,
  input  logic [8:0]  i_adc_sample,
  input  logic        i_arm,
  input  logic [8:0]  i_trig_level,
  input  logic        i_trig_rising,
  input  logic [8:0]  i_rd_addr,
  output logic [8:0]  o_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [8:0]  o_trig_addr
);

  localparam int unsigned DW       = 9;
  localparam int unsigned AW       = 9;
  localparam int unsigned DEPTH    = 512;
  localparam int unsigned CW       = 8;
  localparam int unsigned PRE_CNT  = 256;
  localparam int unsigned POST_CNT = 255;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_sync;
  logic            r_sync_q;
  logic            r_wr_pend;
  logic [DW-1:0]   r_cur, r_prev;
  logic            r_prev_valid, w_prev_valid_nxt;
  logic [AW-1:0]   r_wptr, w_wptr_nxt;
  logic [CW-1:0]   r_scnt, w_scnt_nxt;
  logic [AW-1:0]   r_trig_addr, w_trig_addr_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [DW-1:0]   r_rd_data;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_stb, w_active, w_we, w_rise, w_fall, w_trig_hit, w_auto;
  logic [AW-1:0]   w_rd_phys;

  assign w_stb    = r_sync[1] & ~r_sync_q;
  assign w_active = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_we     = r_wr_pend & w_active & ~i_master_rst;

  // Trigger compares the sample being written against its predecessor.
  assign w_rise     = r_prev_valid && (r_prev < i_trig_level) && (r_cur >= i_trig_level);
  assign w_fall     = r_prev_valid && (r_prev > i_trig_level) && (r_cur <= i_trig_level);
  assign w_trig_hit = i_trig_rising ? w_rise : w_fall;

`ifdef ADC_CAPTURE_AUTO_TRIG_EN
  localparam int unsigned WCW      = 10;
  localparam int unsigned AUTO_CNT = 512;
  logic [WCW-1:0] r_wcnt, w_wcnt_nxt;
  assign w_auto = (r_wcnt == WCW'(AUTO_CNT - 1));

  always_ff @(posedge i_clk_64mhz) begin
    if (i_master_rst) r_wcnt <= '0;
    else              r_wcnt <= w_wcnt_nxt;
  end
`else
  assign w_auto = 1'b0;
`endif

  // CLK_ADC synchronizer, edge strobe and sample pipeline.
  always_ff @(posedge i_clk_64mhz) begin
    if (i_master_rst) begin
      r_sync    <= '0;
      r_sync_q  <= 1'b0;
      r_wr_pend <= 1'b0;
      r_cur     <= '0;
      r_prev    <= '0;
    end else begin
      r_sync    <= {r_sync[0], i_clk_adc};
      r_sync_q  <= r_sync[1];
      r_wr_pend <= w_stb;
      if (w_stb) begin
        r_cur  <= i_adc_sample;
        r_prev <= r_cur;
      end
    end
  end

  always_ff @(posedge i_clk_64mhz) begin
    if (i_master_rst) begin
      r_state      <= S_IDLE;
      r_prev_valid <= 1'b0;
      r_wptr       <= '0;
      r_scnt       <= '0;
      r_trig_addr  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_valid <= w_prev_valid_nxt;
      r_wptr       <= w_wptr_nxt;
      r_scnt       <= w_scnt_nxt;
      r_trig_addr  <= w_trig_addr_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_prev_valid_nxt = r_prev_valid;
    w_wptr_nxt       = r_wptr;
    w_scnt_nxt       = r_scnt;
    w_trig_addr_nxt  = r_trig_addr;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    w_wcnt_nxt       = r_wcnt;
`endif
    if (w_we)            w_wptr_nxt       = r_wptr + AW'(1);
    if (w_stb && w_active) w_prev_valid_nxt = 1'b1;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_arm) begin
          w_state_nxt      = S_PRE;
          w_wptr_nxt       = '0;
          w_scnt_nxt       = '0;
          w_prev_valid_nxt = 1'b0;
        end
      end
      S_PRE: begin
        if (w_we) begin
          if (r_scnt == CW'(PRE_CNT - 1)) begin
            w_state_nxt = S_WAIT;
            w_scnt_nxt  = '0;
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
            w_wcnt_nxt  = '0;
`endif
          end else begin
            w_scnt_nxt = r_scnt + CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (w_we) begin
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
          w_wcnt_nxt = r_wcnt + WCW'(1);
`endif
          if (w_trig_hit || w_auto) begin
            w_trig_addr_nxt = r_wptr;
            w_state_nxt     = S_POST;
            w_scnt_nxt      = '0;
          end
        end
      end
      S_POST: begin
        if (w_we) begin
          if (r_scnt == CW'(POST_CNT - 1)) w_state_nxt = S_DONE;
          else                             w_scnt_nxt  = r_scnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == S_PRE) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_POST);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Logical index 0 is 256 samples before the trigger; -256 == +256 mod 512.
  assign w_rd_phys = r_trig_addr + AW'(PRE_CNT) + i_rd_addr;

  always_ff @(posedge i_clk_64mhz) begin
    if (w_we) r_mem[r_wptr] <= r_cur;
  end

  always_ff @(posedge i_clk_64mhz) begin
    if (i_master_rst) r_rd_data <= '0;
    else              r_rd_data <= r_mem[w_rd_phys];
  end

  assign o_rd_data   = r_rd_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_trig_addr = r_trig_addr;

endmodule

// File: tb/tb_adc_capture.sv
// Directed self-checking bench for adc_capture (ramp, step, re-arm, reset-abort, no-trigger cases).
module tb_adc_capture;

  logic       clk;
  logic       rst;
  logic       clk_adc;
  logic [8:0] adc_sample;
  logic       arm;
  logic [8:0] trig_level;
  logic       trig_rising;
  logic [8:0] rd_addr;
  logic [8:0] rd_data;
  logic       busy;
  logic       done;
  logic [8:0] trig_addr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Sample source controls (written by main process only).
  int          mode = 0;
  logic [8:0]  cval = '0;
  // Sample source state (written by generator only).
  logic [8:0]  ramp = '0;
  int unsigned nsamp = 0;

  adc_capture dut (
    .i_clk_64mhz  (clk),
    .i_master_rst (rst),
    .i_clk_adc    (clk_adc),
    .i_adc_sample (adc_sample),
    .i_arm        (arm),
    .i_trig_level (trig_level),
    .i_trig_rising(trig_rising),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_trig_addr  (trig_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC clock: 5 system cycles per phase; sample updates on its rising edge.
  initial begin
    clk_adc    = 1'b0;
    adc_sample = '0;
    #52;
    forever begin
      clk_adc    = 1'b1;
      adc_sample = (mode == 0) ? ramp : cval;
      ramp       = ramp + 9'd1;
      nsamp      = nsamp + 1;
      #50;
      clk_adc = 1'b0;
      #50;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic wait_samples(input int unsigned n);
    int unsigned target = nsamp + n;
    int unsigned k = 0;
    while (nsamp < target && k < n * 12 + 40) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic wait_done(input string tag, input int unsigned max_cyc);
    int unsigned k = 0;
    while (!done && k < max_cyc) begin
      cyc(1);
      k++;
    end
    check(tag, done, 1);
  endtask

  task automatic read_chk(input string tag, input logic [8:0] addr, input int unsigned exp);
    rd_addr = addr;
    cyc(1);
    check(tag, rd_data, exp);
  endtask

  initial begin
    int unsigned k;
    rst = 1'b1; arm = 1'b0; trig_level = 9'd200; trig_rising = 1'b1; rd_addr = '0;
    cyc(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig_addr", trig_addr, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    cyc(100);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_trig_addr", trig_addr, 0);

    // Rising trigger on a ramp at level 200.
    mode = 0; trig_level = 9'd200; trig_rising = 1'b1;
    pulse_arm();
    check("t1_busy", busy, 1);
    check("t1_done", done, 0);
    wait_done("t1_done_seen", 12000);
    check("t1_busy_end", busy, 0);
    read_chk("t1_rd256", 9'd256, 200);
    read_chk("t1_rd0",   9'd0,   456);
    read_chk("t1_rd511", 9'd511, 455);
    read_chk("t1_rd255", 9'd255, 199);
    read_chk("t1_rd257", 9'd257, 201);
    read_chk("t1_rd1",   9'd1,   457);

    // Falling trigger: constant 300 then a step to 50; ARM in WAIT is ignored.
    mode = 1; cval = 9'd300; trig_level = 9'd100; trig_rising = 1'b0;
    cyc(20);
    pulse_arm();
    wait_samples(300);
    pulse_arm();
    check("t2_arm_in_wait_busy", busy, 1);
    check("t2_arm_in_wait_done", done, 0);
    wait_samples(5);
    cval = 9'd50;
    wait_done("t2_done_seen", 4000);
    read_chk("t2_rd255", 9'd255, 300);
    read_chk("t2_rd256", 9'd256, 50);
    read_chk("t2_rd0",   9'd0,   300);
    read_chk("t2_rd511", 9'd511, 50);

    // ARM in DONE restarts; abort with reset 100 samples into POST.
    pulse_arm();
    check("t3_rearm_busy", busy, 1);
    check("t3_rearm_done", done, 0);
    mode = 0; trig_level = 9'd200; trig_rising = 1'b1;
    wait_samples(270);
    k = 0;
    while (adc_sample != 9'd200 && k < 6000) begin
      cyc(1);
      k++;
    end
    check("t3_saw_200", (adc_sample == 9'd200) ? 1 : 0, 1);
    wait_samples(100);
    check("t3_post_busy", busy, 1);
    rst = 1'b1;
    cyc(1);
    check("t3_rst_busy", busy, 0);
    check("t3_rst_done", done, 0);
    check("t3_rst_trig_addr", trig_addr, 0);
    arm = 1'b1;
    cyc(1);
    check("t3_rst_over_arm_busy", busy, 0);
    rst = 1'b0; arm = 1'b0;
    cyc(2);
    pulse_arm();
    wait_done("t3_done_after_rst", 12000);
    read_chk("t3_rd256", 9'd256, 200);
    read_chk("t3_rd0",   9'd0,   456);

    // Constant input below level: no natural trigger.
    mode = 1; cval = 9'd10; trig_level = 9'd200; trig_rising = 1'b1;
    cyc(20);
    pulse_arm();
`ifdef ADC_CAPTURE_AUTO_TRIG_EN
    wait_samples(256 + 500);
    check("t4_not_yet_done", done, 0);
    wait_done("t4_auto_done", 8000);
    read_chk("t4_rd256", 9'd256, 10);
    read_chk("t4_rd0",   9'd0,   10);
`else
    wait_samples(256 + 512 + 255 + 40);
    check("t4_still_busy", busy, 1);
    check("t4_never_done", done, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 CLK_64MHZ  input  1  system clock; all state in this domain.
REQ-002 MASTER_RST  input  1  reset, synchronous and active-high.
REQ-003 CLK_ADC  input  1  ADC sample clock from the ADC driver; asynchronous-rate square wave, each high and low phase at least 4 CLK_64MHZ cycles.
REQ-004 ADC_SAMPLE  input  9  sample word from the ADC driver; changes only on CLK_ADC rising edge.
REQ-005 ARM  input  1  one-cycle pulse; starts a capture.
REQ-006 TRIG_LEVEL  input  9  unsigned trigger threshold.
REQ-007 TRIG_RISING  input  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-008 RD_ADDR  input  9  logical read index, 0..511; trigger sample sits at index 256.
REQ-009 RD_DATA  output  9  buffered sample at RD_ADDR.
REQ-010 BUSY  output  1  high in PRE, WAIT, POST.
REQ-011 DONE  output  1  high in DONE state.
REQ-012 TRIG_ADDR  output  9  physical buffer address of the trigger sample.

Function
REQ-013 CLK_ADC shall pass through a 2-flop synchronizer; a rising edge on the synchronized signal shall produce a one-cycle strobe STB.
REQ-014 On STB, ADC_SAMPLE shall be registered as the current sample CUR, and the previous CUR shall move to PREV.
REQ-015 Each CUR shall be written to a 512x9 circular buffer at WPTR in the cycle after STB when in PRE, WAIT or POST; after each write, WPTR increments modulo 512.
REQ-016 States: IDLE, PRE, WAIT, POST, DONE; encoding is free.
REQ-017 IDLE: ARM shall go to PRE, clear WPTR and the sample counter SCNT, and clear PREV_VALID.
REQ-018 PRE: after 256 writes, the FSM shall go to WAIT.
REQ-019 WAIT, rising edge: the trigger fires when PREV_VALID, PREV < TRIG_LEVEL and CUR >= TRIG_LEVEL.
REQ-020 WAIT, falling edge: the trigger fires when PREV_VALID, PREV > TRIG_LEVEL and CUR <= TRIG_LEVEL.
REQ-021 On trigger, the address of that sample's write shall latch into TRIG_ADDR, the FSM shall go to POST and SCNT shall clear.
REQ-022 POST: after 255 further writes, the FSM shall go to DONE; the total window is 256 pre + 1 trigger + 255 post = 512 samples.
REQ-023 DONE: no writes occur; ARM shall restart at PRE as from IDLE.
REQ-024 ARM while BUSY shall be ignored.
REQ-025 Reads: physical address = (TRIG_ADDR - 256 + RD_ADDR) mod 512, 9-bit wraparound; RD_DATA shall be registered with 1-cycle latency and shall be valid in any state.
REQ-026 A simultaneous write and read to the same address shall return the old data.
REQ-027 PREV_VALID shall set on the first STB after ARM, so the first sample cannot trigger.
REQ-028 TRIG_LEVEL and TRIG_RISING shall be sampled live, with no latching.

Reset
REQ-029 When MASTER_RST is high on a clock edge, the FSM shall go to IDLE and the following shall clear to 0: BUSY, DONE, TRIG_ADDR, RD_DATA, WPTR, SCNT, CUR, PREV, PREV_VALID and the synchronizer flops.
REQ-030 Buffer contents are not reset.
REQ-031 Reset mid-capture shall abort it; DONE stays 0.
REQ-032 MASTER_RST shall take priority over ARM in the same cycle.

Configuration
REQ-033 Macro ADC_CAPTURE_AUTO_TRIG_EN: when defined, WAIT shall count STBs, and at 512 STBs without a trigger it shall force a trigger on the current sample, with behaviour identical to REQ-021; the counter resets on WAIT entry.
REQ-034 Without ADC_CAPTURE_AUTO_TRIG_EN, WAIT shall persist indefinitely until a trigger or reset; no counter logic exists.

Verification
REQ-035 Reset, then idle for 100 cycles -> BUSY=0, DONE=0, TRIG_ADDR=0, RD_DATA=0, no buffer writes.
REQ-036 TRIG_RISING=1, TRIG_LEVEL=200, ramp input 0,1,2,...(mod 512), ARM -> trigger on sample value 200; after DONE, RD_ADDR=256 gives 200, RD_ADDR=0 gives -56 mod 512 = 456 written value per ramp history, RD_ADDR=511 gives 455.
REQ-037 TRIG_RISING=0, TRIG_LEVEL=100, input constant 300 then a step to 50 -> trigger on the first 50; RD_ADDR=255 gives 300, RD_ADDR=256 gives 50.
REQ-038 ARM pulsed again in WAIT -> no state change; ARM in DONE -> BUSY=1 next cycle, DONE=0.
REQ-039 MASTER_RST asserted during POST at 100 samples -> next cycle IDLE, BUSY=0, DONE=0; a subsequent ARM completes normally.
REQ-040 Constant input 10 with TRIG_LEVEL=200: with ADC_CAPTURE_AUTO_TRIG_EN, DONE shall assert after 256+512+255 STBs; without it, BUSY shall remain high indefinitely.
